// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared definitions for GEMM stream stages: skid-buffer depth, stat width
// and a clog2 helper that never returns 0.
package gemm_stream_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned STAT_W     = 32;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_stream_skid_buf2.sv
// Two-entry in-order buffer; head entry is registered and drives the stream.
// Push is refused when full unless a pop frees a slot in the same cycle.
module stream_skid_buf2
  import gemm_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  head_valid,
  output logic [SKID_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      slot0;
  logic [WIDTH-1:0]      slot1;
  logic [SKID_CNT_W-1:0] cnt;
  logic                  pop_ok;
  logic                  push_ok;

  assign pop_ok  = pop & (cnt != '0);
  assign push_ok = push & ((cnt != SKID_CNT_W'(SKID_DEPTH)) | pop_ok);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == '0) slot0 <= push_data;
          else           slot1 <= push_data;
          cnt <= cnt + SKID_CNT_W'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - SKID_CNT_W'(1);
        end
        // Simultaneous push/pop: the new word lands in whichever slot is the
        // tail once the head has advanced, so ordering is kept.
        2'b11: begin
          if (cnt == SKID_CNT_W'(1)) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data  = slot0;
  assign head_valid = (cnt != '0);
  assign count      = cnt;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// BRAM FIFO read port to valid/ready stream with burst framing (o_last/o_beat_idx).
// Optional accepted-beat/stall counters under FIFO_RD_ADAPTER_STATS_EN.
module fifo_rd_stream_adapter
  import gemm_stream_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned BURST_LEN  = 128,
  localparam int unsigned BEAT_W     = clog2_min1(BURST_LEN)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  output logic                  o_fifo_rd_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic [BEAT_W-1:0]     o_beat_idx,
  output logic                  o_idle,
  output logic [STAT_W-1:0]     o_beat_count,
  output logic [STAT_W-1:0]     o_stall_count
);

  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(BURST_LEN - 1);

  logic                  inflight;
  logic                  pop;
  logic                  issue;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic [2:0]            occ_next;
  logic [BEAT_W-1:0]     beat_cnt;

  assign pop = o_valid & i_ready;

  // Occupancy after this cycle's pop; at most one slot may be committed so
  // the read returning next cycle always has room.
  assign occ_next     = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
  assign o_fifo_rd_en = i_reset_n & i_enable & (occ_next <= 3'd1);
  assign issue        = o_fifo_rd_en & ~i_fifo_empty;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) inflight <= 1'b0;
    else            inflight <= issue;
  end

  stream_skid_buf2 #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (inflight),
    .push_data (i_fifo_rd_data),
    .pop       (pop),
    .head_data (o_data),
    .head_valid(o_valid),
    .count     (buf_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

  assign o_beat_idx = beat_cnt;
  assign o_last     = (beat_cnt == LAST_IDX);
  assign o_idle     = (buf_cnt == '0) & ~inflight;

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [STAT_W-1:0] beat_count;
  logic [STAT_W-1:0] stall_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop && beat_count != '1)
        beat_count <= beat_count + STAT_W'(1);
      if (o_valid && !i_ready && stall_count != '1)
        stall_count <= stall_count + STAT_W'(1);
    end
  end

  assign o_beat_count  = beat_count;
  assign o_stall_count = stall_count;
`else
  assign o_beat_count  = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural FIFO, scoreboard of written
// words, negedge monitor for data order, framing and stall stability.
module tb_fifo_rd_stream_adapter;
  import gemm_stream_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned BL = 4;
  localparam int unsigned BW = clog2_min1(BL);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;
  logic [BW-1:0] beat_idx;
  logic          idle;
  logic [31:0]   beat_count;
  logic [31:0]   stall_count;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_enable      (enable),
    .o_fifo_rd_en  (fifo_rd_en),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_rd_data(fifo_rd_data),
    .o_data        (data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_last        (last),
    .o_beat_idx    (beat_idx),
    .o_idle        (idle),
    .o_beat_count  (beat_count),
    .o_stall_count (stall_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_idx = 0;
  int            tb_beats = 0;
  int            tb_stalls = 0;
  logic [DW-1:0] next_word = 16'h0001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word();
    fifo_q.push_back(next_word);
    exp_q.push_back(next_word);
    next_word = next_word + 16'd1;
  endtask

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) tick();
    exp_q     = fifo_q;
    exp_idx   = 0;
    tb_beats  = 0;
    tb_stalls = 0;
    reset_n   = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !idle) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(idle), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 32'(valid), 32'd1);
  endtask

  // Behavioural BRAM FIFO: registered empty, data one cycle after an accepted
  // read, junk on the data bus otherwise so phantom captures are visible.
  initial begin
    fifo_empty   = 1'b1;
    fifo_rd_data = 16'hDEAD;
    forever begin
      @(posedge clk);
      if (fifo_rd_en && !fifo_empty) fifo_rd_data <= fifo_q.pop_front();
      else                           fifo_rd_data <= 16'hDEAD;
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Stream monitor.
  initial begin
    logic          stalled_prev;
    logic [DW-1:0] hold_data;
    logic [BW-1:0] hold_idx;
    logic          hold_last;
    logic [DW-1:0] exp_word;
    stalled_prev = 1'b0;
    hold_data    = '0;
    hold_idx     = '0;
    hold_last    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        check("buf_cnt_le2", 32'(dut.buf_cnt > 2'd2), 32'd0);
        if (stalled_prev) begin
          check("hold_valid", 32'(valid), 32'd1);
          check("hold_data", 32'(data), 32'(hold_data));
          check("hold_idx", 32'(beat_idx), 32'(hold_idx));
          check("hold_last", 32'(last), 32'(hold_last));
        end
        if (valid && ready) begin
          check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_word = exp_q.pop_front();
            check("beat_data", 32'(data), 32'(exp_word));
          end
          check("beat_idx", 32'(beat_idx), 32'(exp_idx));
          check("beat_last", 32'(last), 32'(exp_idx == int'(BL) - 1));
          exp_idx = (exp_idx + 1) % int'(BL);
          tb_beats++;
        end
        if (valid && !ready) tb_stalls++;
        stalled_prev = valid && !ready;
        hold_data    = data;
        hold_idx     = beat_idx;
        hold_last    = last;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int written;

    // Reset values, read enable forced low even with enable high
    reset_n = 1'b0;
    enable  = 1'b1;
    ready   = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_idx", 32'(beat_idx), 32'd0);
    check("rst_beat_cnt", beat_count, 32'd0);
    check("rst_stall_cnt", stall_count, 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);

    // Preloaded 8 words, continuous ready: T+2 latency, no bubbles
    tick();
    enable = 1'b0;
    repeat (8) push_word();
    tick();
    tick();
    enable = 1'b1;
    @(negedge clk);
    check("issue_T", 32'(fifo_rd_en), 32'd1);
    check("valid_T", 32'(valid), 32'd0);
    @(negedge clk);
    check("valid_T1", 32'(valid), 32'd0);
    @(negedge clk);
    check("valid_T2", 32'(valid), 32'd1);
    repeat (7) begin
      @(negedge clk);
      check("no_bubble", 32'(valid), 32'd1);
    end
    drain(20);
    check("idx_after_8", 32'(beat_idx), 32'd0);
    tick();
    repeat (2) push_word();
    drain(20);
    check("idx_after_10", 32'(beat_idx), 32'd2);

    // Single word then empty while read enable stays high
    b0 = tb_beats;
    tick();
    push_word();
    drain(20);
    repeat (4) @(negedge clk);
    check("single_beat", 32'(tb_beats - b0), 32'd1);
    check("rd_en_on_empty", 32'(fifo_rd_en & fifo_empty), 32'd1);
    check("single_idle", 32'(idle), 32'd1);

    // Reset with a word buffered and one returning from the FIFO
    tick();
    ready  = 1'b0;
    enable = 1'b0;
    repeat (5) push_word();
    tick();
    tick();
    enable = 1'b1;
    tick();
    tick();
    check("pre_rst_inflight_idx", 32'(beat_idx), 32'd3);
    apply_reset(1);
    @(negedge clk);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_idx", 32'(beat_idx), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    check("post_rst_no_beat", 32'(valid), 32'd0);
    tick();
    ready = 1'b1;
    wait_valid(10);
    check("post_rst_first_idx", 32'(beat_idx), 32'd0);
    drain(40);

    // Stats: 20 beats, 7 isolated stall cycles
    tick();
    enable = 1'b0;
    apply_reset(2);
    repeat (20) push_word();
    tick();
    tick();
    enable = 1'b1;
    wait_valid(10);
    repeat (7) begin
      tick();
      ready = 1'b0;
      tick();
      ready = 1'b1;
    end
    drain(100);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check("stat_beats_20", beat_count, 32'd20);
    check("stat_stalls_7", stall_count, 32'd7);
`else
    check("stat_beats_off", beat_count, 32'd0);
    check("stat_stalls_off", stall_count, 32'd0);
`endif

    // Random ready, concurrent FIFO writes, 1000 words
    written = 0;
    while (written < 1000) begin
      tick();
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) begin
        push_word();
        written++;
      end
    end
    tick();
    ready = 1'b1;
    drain(5000);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check("stat_beats_rand", beat_count, 32'(tb_beats));
    check("stat_stalls_rand", stall_count, 32'(tb_stalls));
`else
    check("stat_beats_rand_off", beat_count, 32'd0);
    check("stat_stalls_rand_off", stall_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Sits directly downstream of the team's synchronous BRAM FIFO. That FIFO has registered o_empty, read-enable gated by empty, and read data valid 1 cycle after an accepted read.
- Converts that read port into a valid/ready stream with full throughput (1 beat/cycle) under continuous i_ready.
- Frames the stream into bursts of BURST_LEN beats with o_last/o_beat_idx, so downstream GEMM consumers need no FIFO-latency knowledge.

Parameters:
DATA_WIDTH, 16, width of FIFO word and stream data
BURST_LEN, 128, beats per burst; o_last asserted on beat BURST_LEN-1; must be >= 1
BEAT_W, $clog2(BURST_LEN) (min 1), width of o_beat_idx (localparam)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_enable  in  1  when 0, no new FIFO reads issued; in-flight/buffered beats still drain
o_fifo_rd_en  out  1  read request to FIFO
i_fifo_empty  in  1  FIFO empty flag (registered in FIFO)
i_fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid 1 cycle after accepted read
o_data  out  DATA_WIDTH  stream data (registered)
o_valid  out  1  stream valid (registered)
i_ready  in  1  stream ready
o_last  out  1  final beat of burst, qualified by o_valid
o_beat_idx  out  BEAT_W  index of current o_data beat within burst
o_idle  out  1  buffer empty, nothing in flight
o_beat_count  out  32  accepted-beat counter (see Optional Feature)
o_stall_count  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (i_reset_n=0 at clock edge): o_valid=0, o_data=0, o_last=0, o_beat_idx=0, buffer count=0, inflight=0, counters=0. o_fifo_rd_en is forced 0 while i_reset_n=0. o_idle=1 after reset.
- Reset mid-operation: buffered and in-flight words are discarded. Data returned by the FIFO in the cycle after reset is ignored.
- Read accepted ("issue") = o_fifo_rd_en & ~i_fifo_empty, evaluated in the same cycle. The adapter never assumes a read occurred without this term.
- inflight (0/1) = issue registered. When inflight=1, i_fifo_rd_data is written into the buffer in that cycle.
- Buffer: 2-entry, in order. The head drives o_data/o_valid registered.
- pop = o_valid & i_ready.
- o_fifo_rd_en = i_enable & (buf_cnt + inflight - pop <= 1).
  - Guarantees no overflow: buf_cnt never exceeds 2.
  - Steady state buf_cnt=1, inflight=1 sustains 1 beat/cycle.
- Latency: word present in FIFO with empty=0 at cycle T, buffer empty, ready=1 -> issue at T, o_valid=1 at T+2.
- Simultaneous capture and pop: the head advances and the captured word enters the correct slot; ordering is preserved.
- i_ready=0 with o_valid=1: o_data, o_last and o_beat_idx are held stable until pop.
- Burst framing: beat counter increments on pop and wraps to 0 after BURST_LEN-1. o_last = (beat counter == BURST_LEN-1), aligned to o_data. With BURST_LEN=1, o_last is always 1 and o_beat_idx=0.
- i_enable deassert mid-stream: issue stops that cycle, remaining beats drain, and the beat counter is preserved (no burst restart).
- o_idle = (buf_cnt==0) & (inflight==0).
- Stream rule: once o_valid=1 it stays 1 until pop.

Optional Feature:
- Macro FIFO_RD_ADAPTER_STATS_EN.
- Defined: o_beat_count increments on pop; o_stall_count increments each cycle with o_valid & ~i_ready. Both 32-bit, saturate at 0xFFFFFFFF, reset to 0.
- Undefined: both outputs tied to 0, no counter flops; all other behaviour identical.

Decomposition:
- Shared package gemm_stream_pkg: localparam SKID_DEPTH=2; function clog2_min1(n), used for BEAT_W; STAT_W=32.
- One natural sub-module: stream_skid_buf2 (2-entry buffer).
  - Ports: push, push_data, pop, head_data, head_valid, count.
  - Reused by other GEMM stream stages.
- Framing, issue logic and stats stay in the top module.

Test Plan:
- Preload FIFO with 8 words 0x0001..0x0008, i_ready=1 constantly -> o_valid at T+2 after first issue, 8 consecutive beats 0x0001..0x0008 with no bubbles, then o_idle=1.
- BURST_LEN=4, 10 beats -> o_last on beats 3 and 7 (o_beat_idx=3), o_beat_idx after beat 9 equals 2.
- Random i_ready (50%), 1000 words, FIFO written concurrently -> output sequence equals input sequence, no loss or duplication, buf_cnt<=2 asserted, o_data stable while stalled.
- FIFO holds 1 word, then i_fifo_empty=1 while o_fifo_rd_en=1 -> exactly 1 beat emitted, no phantom capture.
- Reset asserted cycle after an issue, with 2 words buffered -> outputs return to reset values, no beat appears after reset, next burst starts at o_beat_idx=0.
- With FIFO_RD_ADAPTER_STATS_EN: 20 beats and 7 stall cycles -> o_beat_count=20, o_stall_count=7. Without the macro: both read 0.
